// File: rtl/imem_boot_loader.sv
// Streams a program image into instruction memory and holds the CPU in reset.
// Optional checksum check enabled by defining LOADER_CHECKSUM_EN.
module imem_boot_loader #(
  parameter int ADDR_W      = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_count,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
`ifdef LOADER_CHECKSUM_EN
  input  logic [31:0]       expected_sum,
`endif
  output logic              in_ready,
  output logic              write_signal,
  output logic [31:0]       write_address,
  output logic [31:0]       instruction_write,
  output logic              instruction_reset,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_HOLD,
    S_RUN,
    S_ERROR
  } state_t;

  localparam logic [ADDR_W:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  state_t            state, state_n;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   idx;
  logic [HW-1:0]     hold_cnt;
  logic [ADDR_W-1:0] waddr;
  logic              accept;
  logic              last;
  logic              start_ok;
  logic              load_ok;
  logic              zero_ok;

  assign in_ready = (state == S_LOAD) & ~reset;
  assign accept   = in_ready & in_valid;
  assign last     = (idx == cnt - 1'b1);
  assign start_ok = load_start &
                    ((state == S_IDLE) | (state == S_RUN) |
                     (state == S_ERROR));

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] sum_q;
  assign load_ok = ((sum_q + in_data) == expected_sum);
  assign zero_ok = (expected_sum == 32'd0);

  // Running modulo-2^32 sum of accepted words
  always_ff @(posedge clk) begin
    if (reset)
      sum_q <= '0;
    else if (state == S_CLEAR)
      sum_q <= '0;
    else if (accept)
      sum_q <= sum_q + in_data;
  end
`else
  assign load_ok = 1'b1;
  assign zero_ok = 1'b1;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (load_start) state_n = S_CLEAR;
      S_CLEAR: begin
        if (cnt == '0)
          state_n = zero_ok ? S_HOLD : S_ERROR;
        else
          state_n = S_LOAD;
      end
      S_LOAD:  if (accept && last)
                 state_n = load_ok ? S_HOLD : S_ERROR;
      S_HOLD:  if (hold_cnt == HOLD_LAST) state_n = S_RUN;
      S_RUN:   if (load_start) state_n = S_CLEAR;
      S_ERROR: if (load_start) state_n = S_CLEAR;
      default: state_n = S_IDLE;
    endcase
  end

  // Word count latch, word index and hold timer
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      idx      <= '0;
      hold_cnt <= '0;
    end else begin
      if (start_ok)
        cnt <= (load_count > MAX_CNT) ? MAX_CNT : load_count;
      if (state == S_CLEAR) begin
        idx      <= '0;
        hold_cnt <= '0;
      end else begin
        if (accept)
          idx <= idx + 1'b1;
        if (state == S_HOLD)
          hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  // Registered instruction-memory write port
  always_ff @(posedge clk) begin
    if (reset) begin
      write_signal      <= 1'b0;
      waddr             <= '0;
      instruction_write <= '0;
    end else begin
      write_signal <= accept;
      if (accept) begin
        waddr             <= idx[ADDR_W-1:0];
        instruction_write <= in_data;
      end
    end
  end

  assign write_address = 32'(waddr);

  assign cpu_reset         = reset | (state != S_RUN);
  assign instruction_reset = ~reset & (state == S_CLEAR);
  assign busy              = ~reset &
                             ((state == S_CLEAR) | (state == S_LOAD) |
                              (state == S_HOLD));
  assign done              = ~reset & (state == S_RUN);
`ifdef LOADER_CHECKSUM_EN
  assign error             = ~reset & (state == S_ERROR);
`else
  assign error             = 1'b0;
`endif

endmodule

// File: doc/imem_boot_loader.md
IMEM_BOOT_LOADER -- requirements
Module: imem_boot_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, width of the instruction-memory word index (max 2^ADDR_W words).
REQ-002 SHALL have parameter HOLD_CYCLES, default 4, number of cycles the processor is held in reset after loading.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port load_start  input  1  one-cycle request to begin a (re)load.
REQ-006 SHALL have port load_count  input  ADDR_W+1  number of words to load, sampled when load_start is accepted.
REQ-007 SHALL have port in_valid  input  1  upstream word valid.
REQ-008 SHALL have port in_data  input  32  upstream instruction word.
REQ-009 SHALL have port in_ready  output  1  loader accepts a word this cycle.
REQ-010 SHALL have port write_signal  output  1  instruction-memory write enable.
REQ-011 SHALL have port write_address  output  32  instruction-memory word address, zero-extended from ADDR_W.
REQ-012 SHALL have port instruction_write  output  32  word written to instruction memory.
REQ-013 SHALL have port instruction_reset  output  1  instruction-memory clear pulse.
REQ-014 SHALL have port cpu_reset  output  1  reset driven to the processor pipeline.
REQ-015 SHALL have ports busy, done, error  output  1 each  status: in CLEAR/LOAD/HOLD; in RUN; in ERROR.

Function
REQ-016 SHALL implement states IDLE, CLEAR, LOAD, HOLD, RUN, ERROR.
REQ-017 IDLE: cpu_reset=1, in_ready=0; load_start -> CLEAR, latching load_count.
REQ-018 CLEAR: exactly one cycle; instruction_reset=1; -> LOAD, or -> HOLD if latched count is 0.
REQ-019 LOAD: in_ready=1; a word is accepted when in_valid & in_ready.
REQ-020 Accepted word k (k from 0) SHALL appear registered one cycle later: write_signal=1, write_address=k, instruction_write=in_data; write_signal=0 in all other cycles.
REQ-021 On acceptance of word count-1, in_ready SHALL drop in the next cycle and state -> HOLD; no extra word is accepted.
REQ-022 in_valid low in LOAD SHALL stall without timeout; index does not advance.
REQ-023 HOLD: cpu_reset=1 for exactly HOLD_CYCLES cycles, then -> RUN.
REQ-024 RUN: cpu_reset=0, done=1; load_start -> CLEAR with cpu_reset=1 from the next cycle.
REQ-025 load_start SHALL be ignored in CLEAR, LOAD, HOLD.
REQ-026 load_count > 2^ADDR_W SHALL be saturated to 2^ADDR_W.
REQ-027 Word index counter SHALL never wrap; the final address is count-1.

Reset
REQ-028 reset SHALL override everything: next state IDLE, cpu_reset=1, instruction_reset=0, write_signal=0, write_address=0, instruction_write=0, in_ready=0, busy=done=error=0, counters 0.
REQ-029 reset asserted mid-LOAD or mid-HOLD SHALL abort without further writes; a new load_start is required.

Configuration
REQ-030 Macro LOADER_CHECKSUM_EN SHALL, when defined, add input expected_sum (32) and a running 32-bit modulo sum of accepted words, cleared in CLEAR.
REQ-031 With LOADER_CHECKSUM_EN, at end of LOAD a mismatch SHALL go to ERROR (cpu_reset=1, error=1) instead of HOLD; ERROR exits only via load_start (-> CLEAR) or reset; count 0 compares against sum 0.
REQ-032 Without LOADER_CHECKSUM_EN, expected_sum SHALL not exist, error SHALL be constant 0, ERROR unreachable.

Verification
REQ-033 Reset then load_start with count 3, words 0x00001037,0x00208113,0x00410193 back-to-back -> writes at addresses 0,1,2 on consecutive cycles, HOLD 4 cycles, cpu_reset falls, done=1.
REQ-034 Count 2 with in_valid gapped 3 cycles between words -> exactly two write_signal pulses, addresses 0,1, no spurious writes.
REQ-035 Count 0 -> one instruction_reset pulse, no writes, RUN after 1+HOLD_CYCLES cycles.
REQ-036 In RUN, load_start with count 1 -> cpu_reset reasserts next cycle, instruction_reset pulse, single write at address 0, RUN again.
REQ-037 reset asserted on second of four words -> next cycle all outputs at reset values, no further write_signal.
REQ-038 LOADER_CHECKSUM_EN, words 1,2 with expected_sum 4 -> ERROR, error=1, cpu_reset stays 1; with expected_sum 3 -> RUN.
